core_pll_rst_seq: RTL and testbench
===================================

// Module: core_pll_rst_seq
// PURPOSE
//  Reset sequencer and lock monitor for the core PLL (122.88 MHz refclk -> 245.76/122.88 MHz).
//  Sits directly downstream of the PLL: drives its rst, watches its asynchronous locked output,
//  and releases core_rst_n to the JESD204B/LTC2123 capture logic only after lock has been stable.
//  Re-resets the PLL on lock timeout, on lock loss while running, or on software request.
// PARAMETERS
//  CNT_W           16    width of the internal cycle counter
//  PLL_RST_CYCLES  16    refclk cycles pll_rst is held high per reset pulse (>=1)
//  LOCK_TIMEOUT    4096  refclk cycles allowed in WAIT_LOCK before re-reset (>=2)
//  STABLE_CYCLES   1024  refclk cycles locked must stay high before core release (>=1)
// PORTS
//  refclk         in   1  free-running PLL reference clock; the only clock
//  rst_n          in   1  asynchronous active-low reset
//  pll_locked     in   1  PLL locked (asynchronous to refclk)
//  soft_rst       in   1  synchronous one-cycle software re-reset request
//  pll_rst        out  1  to PLL rst, active high
//  core_rst_n     out  1  downstream core reset, active low
//  locked_stable  out  1  high only in RUN
//  timeout_cnt    out  8  saturating count of WAIT_LOCK timeouts
//  lock_loss_cnt  out  8  saturating count of lock losses in RUN
// BEHAVIOUR
//  - rst_n low (async): state=PLL_RST, cnt=0, sync flops=0, pll_rst=1, core_rst_n=0,
//    locked_stable=0, timeout_cnt=0, lock_loss_cnt=0.
//  - pll_locked passes through a 2-flop synchronizer -> lock_s (2-cycle latency).
//  - Outputs are registered and change on the same edge as the state register.
//  - cnt clears on every state change.
//  - PLL_RST: pll_rst=1. When cnt==PLL_RST_CYCLES-1 -> WAIT_LOCK.
//  - WAIT_LOCK: pll_rst=0.
//      - lock_s=1 -> STABLE.
//      - Otherwise, when cnt==LOCK_TIMEOUT-1 -> PLL_RST and timeout_cnt++.
//  - STABLE:
//      - lock_s=0 -> WAIT_LOCK; the glitch restarts the qualification.
//      - When cnt==STABLE_CYCLES-1 with lock_s=1 -> RUN.
//  - RUN: core_rst_n=1, locked_stable=1. lock_s=0 -> PLL_RST and lock_loss_cnt++.
//    Both outputs drop on that same edge.
//  - soft_rst=1 in any state -> PLL_RST on the next edge. It has priority over every other transition.
//    Simultaneous soft_rst and lock_s=0 in RUN -> PLL_RST, and lock_loss_cnt still increments.
//  - Both 8-bit counters saturate at 255 (no wrap). They are cleared only by rst_n.
//  - core_rst_n=0 and locked_stable=0 in every state except RUN.
// CONFIGURATION
//  CORE_PLL_LOCK_LOSS_CNT_EN defined:
//    - lock_loss_cnt and timeout_cnt are implemented as described above.
//  Not defined:
//    - Both counter ports are tied to 8'd0 and their registers are removed.
//    - State sequencing is otherwise identical.
// TESTING (PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8; macro defined)
//  1. pll_locked=1 constant, release rst_n:
//     - pll_rst high for edges 1-4, low from edge 5.
//     - core_rst_n and locked_stable rise on edge 14 (4 + 1 + 8 + 1).
//  2. pll_locked=0 constant:
//     - pll_rst re-pulses high for 4 cycles every 36 cycles.
//     - timeout_cnt counts 1,2,3,... and holds at 255 after 255 timeouts.
//  3. In STABLE, drop pll_locked for 3 cycles, then hold it high:
//     - Returns to WAIT_LOCK and requalifies from zero.
//     - core_rst_n stays 0 until 8 full stable cycles have elapsed.
//  4. In RUN, drop pll_locked:
//     - core_rst_n=0 and pll_rst=1 on the 3rd edge after the fall.
//     - lock_loss_cnt goes 0->1.
//     - 300 repeats leave it at 255.
//  5. In RUN, pulse soft_rst for 1 cycle:
//     - pll_rst=1 and core_rst_n=0 on the next edge.
//     - Counters unchanged; full sequence recurs.
//  6. Assert rst_n mid-WAIT_LOCK, away from a clock edge:
//     - All outputs take their reset values immediately.
//     - Counters return to 0.

Source files
------------

// File: rtl/core_pll_rst_seq.sv
// Core PLL reset sequencer and lock monitor.
// Define CORE_PLL_LOCK_LOSS_CNT_EN to build the timeout/lock-loss counters.
module core_pll_rst_seq #(
  parameter int CNT_W          = 16,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int STABLE_CYCLES  = 1024
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_rst,
  output logic       pll_rst,
  output logic       core_rst_n,
  output logic       locked_stable,
  output logic [7:0] timeout_cnt,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [1:0] {
    PLL_RST_S,
    WAIT_LOCK_S,
    STABLE_S,
    RUN_S
  } state_e;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             meta_q, lock_s_q;
  logic             pll_rst_q, core_rst_n_q, stable_q;
  logic             restart;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q   <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      meta_q   <= pll_locked;
      lock_s_q <= meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    if (soft_rst) begin
      state_d = PLL_RST_S;
    end else begin
      unique case (state_q)
        PLL_RST_S: begin
          if (cnt_q == RST_LAST) state_d = WAIT_LOCK_S;
        end
        WAIT_LOCK_S: begin
          if (lock_s_q) state_d = STABLE_S;
          else if (cnt_q == TO_LAST) state_d = PLL_RST_S;
        end
        STABLE_S: begin
          if (!lock_s_q) state_d = WAIT_LOCK_S;
          else if (cnt_q == STB_LAST) state_d = RUN_S;
        end
        RUN_S: begin
          if (!lock_s_q) state_d = PLL_RST_S;
        end
      endcase
    end
  end

  // soft_rst restarts the pulse even when already in PLL_RST
  assign restart = soft_rst | (state_d != state_q);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PLL_RST_S;
      cnt_q        <= '0;
      pll_rst_q    <= 1'b1;
      core_rst_n_q <= 1'b0;
      stable_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= restart ? '0 : cnt_q + CNT_W'(1);
      pll_rst_q    <= (state_d == PLL_RST_S);
      core_rst_n_q <= (state_d == RUN_S);
      stable_q     <= (state_d == RUN_S);
    end
  end

  assign pll_rst       = pll_rst_q;
  assign core_rst_n    = core_rst_n_q;
  assign locked_stable = stable_q;

`ifdef CORE_PLL_LOCK_LOSS_CNT_EN
  logic [7:0] to_cnt_q, ll_cnt_q;
  logic       to_evt, ll_evt;

  assign to_evt = !soft_rst && (state_q == WAIT_LOCK_S) &&
                  !lock_s_q && (cnt_q == TO_LAST);
  // a lock loss counts even when soft_rst wins the transition
  assign ll_evt = (state_q == RUN_S) && !lock_s_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= 8'd0;
      ll_cnt_q <= 8'd0;
    end else begin
      if (to_evt && to_cnt_q != 8'hFF) to_cnt_q <= to_cnt_q + 8'd1;
      if (ll_evt && ll_cnt_q != 8'hFF) ll_cnt_q <= ll_cnt_q + 8'd1;
    end
  end

  assign timeout_cnt   = to_cnt_q;
  assign lock_loss_cnt = ll_cnt_q;
`else
  assign timeout_cnt   = 8'd0;
  assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_core_pll_rst_seq.sv
// Bench for core_pll_rst_seq: phase/age model checked every cycle
// plus directed literal checks of the key timings.
module tb_core_pll_rst_seq;

  localparam int P = 4;
  localparam int T = 32;
  localparam int S = 8;
`ifdef CORE_PLL_LOCK_LOSS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       refclk     = 1'b0;
  logic       rst_n      = 1'b0;
  logic       pll_locked = 1'b0;
  logic       soft_rst   = 1'b0;
  logic       pll_rst, core_rst_n, locked_stable;
  logic [7:0] timeout_cnt, lock_loss_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  core_pll_rst_seq #(
    .CNT_W         (16),
    .PLL_RST_CYCLES(P),
    .LOCK_TIMEOUT  (T),
    .STABLE_CYCLES (S)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .soft_rst     (soft_rst),
    .pll_rst      (pll_rst),
    .core_rst_n   (core_rst_n),
    .locked_stable(locked_stable),
    .timeout_cnt  (timeout_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Model: phase 0=reset pulse, 1=awaiting lock, 2=qualifying, 3=running;
  // age = cycles spent in the current phase; lock seen 2 edges late.
  int       m_ph   = 0;
  int       m_age  = 0;
  int       m_to   = 0;
  int       m_ll   = 0;
  bit [1:0] m_sync = 2'b00;

  always @(posedge refclk or negedge rst_n) begin
    bit ls;
    int nx;
    if (!rst_n) begin
      m_ph = 0; m_age = 0; m_to = 0; m_ll = 0; m_sync = 2'b00;
    end else begin
      ls = m_sync[1];
      nx = m_ph;
      if (m_ph == 3 && !ls && m_ll < 255) m_ll = m_ll + 1;
      if (soft_rst) nx = 0;
      else if (m_ph == 0 && m_age == P - 1) nx = 1;
      else if (m_ph == 1 && ls) nx = 2;
      else if (m_ph == 1 && m_age == T - 1) begin
        nx = 0;
        if (m_to < 255) m_to = m_to + 1;
      end
      else if (m_ph == 2 && !ls) nx = 1;
      else if (m_ph == 2 && m_age == S - 1) nx = 3;
      else if (m_ph == 3 && !ls) nx = 0;
      m_age  = (soft_rst || nx != m_ph) ? 0 : m_age + 1;
      m_ph   = nx;
      m_sync = {m_sync[0], pll_locked};
    end
  end

  always @(negedge refclk) begin
    chk("m pll_rst", {7'd0, pll_rst}, {7'd0, m_ph == 0});
    chk("m core_rst_n", {7'd0, core_rst_n}, {7'd0, m_ph == 3});
    chk("m locked_stable", {7'd0, locked_stable}, {7'd0, m_ph == 3});
    chk("m timeout_cnt", timeout_cnt, CNT_EN ? 8'(m_to) : 8'd0);
    chk("m lock_loss_cnt", lock_loss_cnt, CNT_EN ? 8'(m_ll) : 8'd0);
  end

  initial begin
    logic pr [0:14];
    logic cr [0:14];
    logic sr [0:14];
    int   rises [0:3];
    int   nr, width;
    logic prev, found;

    // reset values and test 1: constant lock
    pll_locked = 1'b1;
    repeat (2) @(negedge refclk);
    chk("rst pll_rst", {7'd0, pll_rst}, 8'd1);
    chk("rst core_rst_n", {7'd0, core_rst_n}, 8'd0);
    chk("rst timeout_cnt", timeout_cnt, 8'd0);
    rst_n = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) @(negedge refclk);
      pr[k] = pll_rst;
      cr[k] = core_rst_n;
      sr[k] = locked_stable;
    end
    chk("t1 pll_rst before edge1", {7'd0, pr[0]}, 8'd1);
    chk("t1 pll_rst before edge4", {7'd0, pr[3]}, 8'd1);
    chk("t1 pll_rst before edge5", {7'd0, pr[4]}, 8'd0);
    chk("t1 core before edge13", {7'd0, cr[12]}, 8'd0);
    chk("t1 core before edge14", {7'd0, cr[13]}, 8'd1);
    chk("t1 stable before edge14", {7'd0, sr[13]}, 8'd1);

    // test 5: soft reset from RUN
    soft_rst = 1'b1;
    @(negedge refclk);
    soft_rst = 1'b0;
    chk("t5 pll_rst", {7'd0, pll_rst}, 8'd1);
    chk("t5 core_rst_n", {7'd0, core_rst_n}, 8'd0);
    chk("t5 lock_loss_cnt", lock_loss_cnt, 8'd0);
    repeat (12) @(negedge refclk);
    chk("t5 core before rerun", {7'd0, core_rst_n}, 8'd0);
    @(negedge refclk);
    chk("t5 core rerun", {7'd0, core_rst_n}, 8'd1);

    // test 3: 3-cycle glitch while qualifying
    soft_rst = 1'b1;
    @(negedge refclk);
    soft_rst = 1'b0;
    repeat (6) @(negedge refclk);
    pll_locked = 1'b0;
    repeat (3) @(negedge refclk);
    pll_locked = 1'b1;
    repeat (10) @(negedge refclk);
    chk("t3 core early", {7'd0, core_rst_n}, 8'd0);
    @(negedge refclk);
    chk("t3 core requal", {7'd0, core_rst_n}, 8'd1);

    // test 4: lock loss in RUN, repeated to saturation
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      repeat (2) @(negedge refclk);
      if (i == 0) chk("t4 core held", {7'd0, core_rst_n}, 8'd1);
      @(negedge refclk);
      if (i == 0) begin
        chk("t4 core drop", {7'd0, core_rst_n}, 8'd0);
        chk("t4 pll_rst", {7'd0, pll_rst}, 8'd1);
        chk("t4 ll first", lock_loss_cnt, CNT_EN ? 8'd1 : 8'd0);
      end
      if (i == 1) chk("t4 ll second", lock_loss_cnt, CNT_EN ? 8'd2 : 8'd0);
      pll_locked = 1'b1;
      repeat (20) @(negedge refclk);
    end
    chk("t4 ll saturated", lock_loss_cnt, CNT_EN ? 8'd255 : 8'd0);
    chk("t4 back in run", {7'd0, core_rst_n}, 8'd1);

    // test 2: no lock at all -> periodic timeouts
    pll_locked = 1'b0;
    nr = 0; width = 0;
    prev = pll_rst;
    for (int k = 1; k <= 80; k++) begin
      @(negedge refclk);
      if (pll_rst && !prev && nr < 4) begin
        rises[nr] = k;
        nr++;
      end
      if (k >= 3 && k < 39 && pll_rst) width++;
      prev = pll_rst;
    end
    chk("t2 pulse count", 8'(nr), 8'd3);
    chk("t2 first rise", 8'(rises[0]), 8'd3);
    chk("t2 period a", 8'(rises[1] - rises[0]), 8'd36);
    chk("t2 period b", 8'(rises[2] - rises[1]), 8'd36);
    chk("t2 pulse width", 8'(width), 8'd4);
    chk("t2 to two", timeout_cnt, CNT_EN ? 8'd2 : 8'd0);
    repeat (258 * 36) @(negedge refclk);
    chk("t2 to saturated", timeout_cnt, CNT_EN ? 8'd255 : 8'd0);

    // test 6: async reset in the middle of WAIT_LOCK
    found = 1'b0;
    prev  = pll_rst;
    for (int k = 0; k < 80 && !found; k++) begin
      @(negedge refclk);
      if (prev && !pll_rst) found = 1'b1;
      prev = pll_rst;
    end
    chk("t6 reached wait", {7'd0, found}, 8'd1);
    repeat (5) @(negedge refclk);
    @(posedge refclk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 pll_rst", {7'd0, pll_rst}, 8'd1);
    chk("t6 core_rst_n", {7'd0, core_rst_n}, 8'd0);
    chk("t6 locked_stable", {7'd0, locked_stable}, 8'd0);
    chk("t6 timeout_cnt", timeout_cnt, 8'd0);
    chk("t6 lock_loss_cnt", lock_loss_cnt, 8'd0);
    @(negedge refclk);
    rst_n = 1'b1;
    repeat (4) @(negedge refclk);
    chk("t6 post pll_rst", {7'd0, pll_rst}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
